// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the cost/neighbour memory arbiter
//
// Purpose : default widths, arbiter state encoding, owner encoding and the
//           state-to-owner helper used by mem_arbiter.
// Ports   : none (package)
package arb_pkg;

  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_WORD_W   = 16;
  localparam int DEF_MAX_HOLD = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_A    = 2'd1,
    OWNER_B    = 2'd2
  } owner_t;

  function automatic owner_t state_owner(input state_t s);
    case (s)
      OWN_A:   return OWNER_A;
      OWN_B:   return OWNER_B;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// rtl/arb_hold_timer.sv - hold counter flagging the last permitted owned cycle
//
// Purpose : counts cycles spent in an owned state; expired is high during the
//           MAX_HOLD-th consecutive owned cycle.
// Ports   : clock   - system clock, rising edge
//           rst     - asynchronous active-high reset
//           clear   - zero the counter at the next edge (entry to a new owner)
//           enable  - advance the counter at the next edge
//           expired - counter has reached MAX_HOLD-1
module arb_hold_timer #(
  parameter int MAX_HOLD = 1024
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The arbiter always leaves the owned state on expiry, so the counter
  // never needs to wrap past LAST.
  assign expired = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port lock/round-robin arbiter for the single-port neighbour memory
//
// Purpose : grants one requester at a time with hold-until-release locking,
//           round-robin tie-break and a hold timeout; muxes the owner onto the
//           memory and steers the 1-cycle-latency read data back to its issuer.
// Ports   : clock, rst                     - clock, asynchronous active-high reset
//           req_x/gnt_x                     - request held for a transaction / grant
//           addr_x/wr_en_x/wdata_x/rdata_x  - per-port memory access
//           timeout_x                       - one-cycle pulse when port x is revoked
//           mem_addr/mem_wr_en/mem_wdata    - to memory
//           mem_rdata                       - from memory (synchronous read)
//           busy                            - any grant active
//           grant_cnt_a/grant_cnt_b/timeout_cnt - saturating statistics,
//                                             present only with ARB_STATS_EN
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_a,
  output logic              gnt_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              wr_en_a,
  input  logic [WORD_W-1:0] wdata_a,
  output logic [WORD_W-1:0] rdata_a,
  output logic              timeout_a,
  input  logic              req_b,
  output logic              gnt_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              wr_en_b,
  input  logic [WORD_W-1:0] wdata_b,
  output logic [WORD_W-1:0] rdata_b,
  output logic              timeout_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       grant_cnt_a,
  output logic [15:0]       grant_cnt_b,
  output logic [7:0]        timeout_cnt,
`endif
  output logic              busy
);

  state_t state, state_nx;
  owner_t last_owner, last_owner_nx;
  owner_t owner_d;
  logic   lock_a, lock_b;
  logic   revoke_a, revoke_b;
  logic   elig_a, elig_b;
  logic   hold_expired;
  logic   timer_clear, timer_en;

  assign elig_a = req_a & ~lock_a;
  assign elig_b = req_b & ~lock_b;

  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    revoke_a      = 1'b0;
    revoke_b      = 1'b0;
    case (state)
      IDLE: begin
        if (elig_a && elig_b) begin
          state_nx = (last_owner == OWNER_A) ? OWN_B : OWN_A;
        end else if (elig_a) begin
          state_nx = OWN_A;
        end else if (elig_b) begin
          state_nx = OWN_B;
        end
      end
      OWN_A: begin
        // Release takes priority: expiry with req already low is not a timeout.
        if (!req_a || hold_expired) begin
          revoke_a      = req_a;
          last_owner_nx = OWNER_A;
          state_nx      = elig_b ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (!req_b || hold_expired) begin
          revoke_b      = req_b;
          last_owner_nx = OWNER_B;
          state_nx      = elig_a ? OWN_A : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Any state change is either an entry to a new owner or a drop to IDLE;
  // clearing on both keeps the counter fresh for the next entry.
  assign timer_clear = (state_nx != state);
  assign timer_en    = (state != IDLE);

  arb_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clock   (clock),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (hold_expired)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWNER_B;
      owner_d    <= OWNER_NONE;
      lock_a     <= 1'b0;
      lock_b     <= 1'b0;
      timeout_a  <= 1'b0;
      timeout_b  <= 1'b0;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      owner_d    <= state_owner(state);
      timeout_a  <= revoke_a;
      timeout_b  <= revoke_b;
      // A timed-out port stays locked until it is seen with req low.
      if (revoke_a)    lock_a <= 1'b1;
      else if (!req_a) lock_a <= 1'b0;
      if (revoke_b)    lock_b <= 1'b1;
      else if (!req_b) lock_b <= 1'b0;
    end
  end

  assign gnt_a = (state == OWN_A);
  assign gnt_b = (state == OWN_B);
  assign busy  = gnt_a | gnt_b;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    if (gnt_a) begin
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
      mem_wr_en = wr_en_a;
    end else if (gnt_b) begin
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
      mem_wr_en = wr_en_b;
    end
  end

  // Read data belongs to whoever owned the memory on the issuing cycle.
  assign rdata_a = (owner_d == OWNER_A) ? mem_rdata : '0;
  assign rdata_b = (owner_d == OWNER_B) ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  logic enter_a, enter_b;

  assign enter_a = (state_nx == OWN_A) && (state != OWN_A);
  assign enter_b = (state_nx == OWN_B) && (state != OWN_B);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
      timeout_cnt <= '0;
    end else begin
      if (enter_a && (grant_cnt_a != 16'hFFFF)) grant_cnt_a <= grant_cnt_a + 16'd1;
      if (enter_b && (grant_cnt_b != 16'hFFFF)) grant_cnt_b <= grant_cnt_b + 16'd1;
      if ((revoke_a || revoke_b) && (timeout_cnt != 8'hFF)) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed plus randomized check of mem_arbiter against a behavioural model
module tb_mem_arbiter;

  localparam int AW = 11;
  localparam int WW = 16;
  localparam int MH = 8;

  logic          clock = 1'b0;
  logic          rst;
  logic          req_a, gnt_a, wr_en_a, timeout_a;
  logic [AW-1:0] addr_a;
  logic [WW-1:0] wdata_a, rdata_a;
  logic          req_b, gnt_b, wr_en_b, timeout_b;
  logic [AW-1:0] addr_b;
  logic [WW-1:0] wdata_b, rdata_b;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [WW-1:0] mem_wdata, mem_rdata;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [15:0]   grant_cnt_a, grant_cnt_b;
  logic [7:0]    timeout_cnt;
`endif

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .WORD_W(WW), .MAX_HOLD(MH)) dut (
    .clock     (clock),
    .rst       (rst),
    .req_a     (req_a),
    .gnt_a     (gnt_a),
    .addr_a    (addr_a),
    .wr_en_a   (wr_en_a),
    .wdata_a   (wdata_a),
    .rdata_a   (rdata_a),
    .timeout_a (timeout_a),
    .req_b     (req_b),
    .gnt_b     (gnt_b),
    .addr_b    (addr_b),
    .wr_en_b   (wr_en_b),
    .wdata_b   (wdata_b),
    .rdata_b   (rdata_b),
    .timeout_b (timeout_b),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef ARB_STATS_EN
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b),
    .timeout_cnt (timeout_cnt),
`endif
    .busy      (busy)
  );

  function automatic logic [WW-1:0] preload_val(input int i);
    return WW'(i * 7 + 32'h1234);
  endfunction

  // Single-port memory instance with synchronous read.
  logic [WW-1:0] mem [0:2047];
  logic          preload;
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= preload_val(i);
      mem_rdata <= '0;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: owner 0=none 1=A 2=B; held = cycles owned so far incl. current.
  int            m_owner, m_held, m_last, m_prev;
  bit            m_lock_a, m_lock_b, m_to_a, m_to_b;
  logic [WW-1:0] m_rd;
  logic [WW-1:0] ref_mem [0:2047];
  int            m_ga, m_gb, m_tc;

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_last = 2; m_prev = 0;
    m_lock_a = 0; m_lock_b = 0; m_to_a = 0; m_to_b = 0;
    m_rd = '0; m_ga = 0; m_gb = 0; m_tc = 0;
  endtask

  task automatic check_outputs();
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wd;
    e_we   = (m_owner == 1) ? wr_en_a : (m_owner == 2) ? wr_en_b : 1'b0;
    e_addr = (m_owner == 1) ? addr_a  : (m_owner == 2) ? addr_b  : '0;
    e_wd   = (m_owner == 1) ? wdata_a : (m_owner == 2) ? wdata_b : '0;
    chk("gnt_a",     32'(gnt_a),     32'(m_owner == 1));
    chk("gnt_b",     32'(gnt_b),     32'(m_owner == 2));
    chk("busy",      32'(busy),      32'(m_owner != 0));
    chk("timeout_a", 32'(timeout_a), 32'(m_to_a));
    chk("timeout_b", 32'(timeout_b), 32'(m_to_b));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_we));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("rdata_a",   32'(rdata_a),   32'((m_prev == 1) ? m_rd : '0));
    chk("rdata_b",   32'(rdata_b),   32'((m_prev == 2) ? m_rd : '0));
`ifdef ARB_STATS_EN
    chk("grant_cnt_a", 32'(grant_cnt_a), 32'(m_ga));
    chk("grant_cnt_b", 32'(grant_cnt_b), 32'(m_gb));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(m_tc));
`endif
  endtask

  // Called at posedge+1 with inputs already set; returns at next posedge+1.
  task automatic cycle();
    int n_owner, n_held, n_last, a;
    bit ea, eb, rq, ta, tb, we;
    #1;
    check_outputs();
    ea = req_a && !m_lock_a;
    eb = req_b && !m_lock_b;
    n_owner = m_owner; n_last = m_last; ta = 0; tb = 0;
    if (m_owner == 0) begin
      if (ea && eb)  n_owner = (m_last == 1) ? 2 : 1;
      else if (ea)   n_owner = 1;
      else if (eb)   n_owner = 2;
    end else begin
      rq = (m_owner == 1) ? req_a : req_b;
      if (!rq || m_held == MH) begin
        if (m_owner == 1) begin ta = rq; n_owner = eb ? 2 : 0; end
        else              begin tb = rq; n_owner = ea ? 1 : 0; end
        n_last = m_owner;
      end
    end
    n_held = (n_owner == 0) ? 0 : (n_owner != m_owner) ? 1 : m_held + 1;
    a  = (m_owner == 1) ? int'(addr_a) : (m_owner == 2) ? int'(addr_b) : 0;
    we = (m_owner == 1) ? wr_en_a : (m_owner == 2) ? wr_en_b : 1'b0;
    m_rd = ref_mem[a];
    if (we) ref_mem[a] = (m_owner == 1) ? wdata_a : wdata_b;
    if (n_owner == 1 && m_owner != 1 && m_ga < 65535) m_ga++;
    if (n_owner == 2 && m_owner != 2 && m_gb < 65535) m_gb++;
    if ((ta || tb) && m_tc < 255) m_tc++;
    @(posedge clock);
    m_prev   = m_owner;
    m_owner  = n_owner;
    m_held   = n_held;
    m_last   = n_last;
    m_lock_a = ta ? 1'b1 : (!req_a ? 1'b0 : m_lock_a);
    m_lock_b = tb ? 1'b1 : (!req_b ? 1'b0 : m_lock_b);
    m_to_a   = ta;
    m_to_b   = tb;
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; wr_en_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; wr_en_b = 0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    int g, t;
    idle_inputs();
    rst = 1'b1;
    preload = 1'b1;
    model_reset();
    for (int i = 0; i < 2048; i++) ref_mem[i] = preload_val(i);
    repeat (2) @(posedge clock);
    preload = 1'b0;
    #1;
    chk("reset_gnt_a", 32'(gnt_a), 0);
    chk("reset_gnt_b", 32'(gnt_b), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_mem_wr_en", 32'(mem_wr_en), 0);
    chk("reset_rdata_a", 32'(rdata_a), 0);
    chk("reset_timeout_a", 32'(timeout_a), 0);
    @(posedge clock);
    #1;
    rst = 1'b0;

    // Tie out of reset: A first, then back-to-back handoff to B.
    req_a = 1; req_b = 1; cycle();
    chk("tie_gnt_a", 32'(gnt_a), 1);
    chk("tie_gnt_b", 32'(gnt_b), 0);
    cycle();
    req_a = 0; cycle();
    chk("handoff_gnt_b", 32'(gnt_b), 1);
    chk("handoff_gnt_a", 32'(gnt_a), 0);
    req_b = 0; cycle(); cycle();

    // Single owner: write then read back 0x005.
    req_a = 1; cycle();
    chk("single_gnt_a", 32'(gnt_a), 1);
    addr_a = 11'h005; wr_en_a = 1; wdata_a = 16'h00AA; cycle();
    wr_en_a = 0; cycle();
    req_a = 0;
    chk("single_rdata_a", 32'(rdata_a), 32'h00AA);
    chk("single_rdata_b", 32'(rdata_b), 0);
    cycle(); cycle();

    // Isolation: B drives a write without owning.
    idle_inputs();
    req_a = 1; cycle();
    addr_a = 11'h020; wr_en_a = 1; wdata_a = 16'h1111;
    addr_b = 11'h010; wr_en_b = 1; wdata_b = 16'hDEAD;
    repeat (3) cycle();
    req_a = 0; wr_en_a = 0; cycle();
    idle_inputs(); cycle(); cycle();
    chk("isolation_mem_010", 32'(mem[16]), 32'(preload_val(16)));

    // Timeout: A holds request for 20 cycles.
    g = 0; t = 0;
    for (int i = 0; i < 20; i++) begin
      req_a = 1;
      if (gnt_a) g++;
      if (timeout_a) t++;
      cycle();
    end
    chk("timeout_gnt_cycles", 32'(g), MH);
    chk("timeout_pulses", 32'(t), 1);
    chk("timeout_locked", 32'(gnt_a), 0);
    req_a = 0; cycle();
    req_a = 1; cycle();
    chk("timeout_regrant", 32'(gnt_a), 1);
    req_a = 0; cycle(); cycle();

    // Reset in the middle of a B write.
    req_b = 1; cycle();
    addr_b = 11'h030; wr_en_b = 1; wdata_b = 16'hBEEF;
    #1;
    check_outputs();
    rst = 1'b1;
    #1;
    chk("midrst_gnt_b", 32'(gnt_b), 0);
    chk("midrst_mem_wr_en", 32'(mem_wr_en), 0);
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b0;
    idle_inputs();
    req_a = 1; req_b = 1; cycle();
    chk("midrst_tie_gnt_a", 32'(gnt_a), 1);
    req_a = 0; req_b = 0; cycle(); cycle();
    chk("midrst_mem_030", 32'(mem[48]), 32'(preload_val(48)));

    // Statistics scenario: three A grants then one B timeout.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req_a = 1; cycle(); cycle();
      req_a = 0; cycle(); cycle();
    end
    req_b = 1; repeat (12) cycle();
    req_b = 0; cycle(); cycle();
`ifdef ARB_STATS_EN
    chk("stats_grant_cnt_a", 32'(grant_cnt_a), 3);
    chk("stats_timeout_cnt", 32'(timeout_cnt), 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) req_a = ~req_a;
      if ($urandom_range(5) == 0) req_b = ~req_b;
      addr_a  = AW'($urandom_range(15));
      addr_b  = AW'($urandom_range(15));
      wr_en_a = 1'($urandom_range(1));
      wr_en_b = 1'($urandom_range(1));
      wdata_a = WW'($urandom);
      wdata_b = WW'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
